// File: rtl/fir_tdm.sv
// Time-multiplexed multi-channel fixed-point FIR, 3-cycle latency, per-tap product wordlengths.
// Define FIR_TDM_SAT_EN to clamp out-of-range results; otherwise they wrap.
module fir_tdm #(
  parameter int N_TAPS      = 15,
  parameter int N_CH        = 2,
  parameter int COE_INTE_WL = 4,
  parameter int COE_FRAC_WL = 8,
  parameter int IN_INTE_WL  = 4,
  parameter int IN_FRAC_WL  = 8,
  parameter int OUT_INTE_WL = 4,
  parameter int OUT_FRAC_WL = 8,
  parameter int PRODUCT_FRAC_WL_ARRAY [0:N_TAPS-1] = '{default: 16},
  parameter int COE_ARRAY [0:N_TAPS-1] = '{0: 256, default: 0},
  parameter int ROUND_MODE  = 0,
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [IN_INTE_WL+IN_FRAC_WL-1:0]    data_in,
  input  logic [CW-1:0]                       in_ch,
  input  logic                                in_valid,
  output logic [OUT_INTE_WL+OUT_FRAC_WL-1:0]  data_out,
  output logic [CW-1:0]                       out_ch,
  output logic                                out_valid,
  output logic                                ovf
);

  localparam int IN_W      = IN_INTE_WL + IN_FRAC_WL;
  localparam int COE_W     = COE_INTE_WL + COE_FRAC_WL;
  localparam int OUT_W     = OUT_INTE_WL + OUT_FRAC_WL;
  localparam int FULL_FRAC = IN_FRAC_WL + COE_FRAC_WL;

  function automatic int max_pf();
    int m = 0;
    for (int k = 0; k < N_TAPS; k++) begin
      if (PRODUCT_FRAC_WL_ARRAY[k] > m) m = PRODUCT_FRAC_WL_ARRAY[k];
    end
    return m;
  endfunction

  localparam int ACC_FRAC = max_pf();
  localparam int ACC_W    = IN_INTE_WL + COE_INTE_WL + $clog2(N_TAPS) + ACC_FRAC;
  localparam int WW       = ACC_W + FULL_FRAC + 2;
  localparam int QW       = ACC_W + OUT_FRAC_WL + 2;

  localparam logic signed [QW-1:0] OMAX = QW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [QW-1:0] OMIN = ~OMAX;

  logic signed [IN_W-1:0]  line_q [N_CH][N_TAPS];
  logic signed [IN_W-1:0]  tap_d  [N_TAPS];
  logic signed [IN_W-1:0]  tap_q  [N_TAPS];
  logic signed [ACC_W-1:0] prod_d [N_TAPS];
  logic signed [ACC_W-1:0] prod_q [N_TAPS];
  logic signed [ACC_W-1:0] sum_d, sum_q;
  logic [CW-1:0]           ch0_q, ch1_q, ch2_q;
  logic                    v0_q, v1_q, v2_q;
  logic                    accept;
  logic signed [QW-1:0]    wide, q;
  logic                    ovf_d;
  logic [OUT_W-1:0]        dout_d;

  assign accept = in_valid && (int'(in_ch) < N_CH);

  // New contents of the addressed channel's line; doubles as the tap snapshot.
  always_comb begin
    for (int k = 0; k < N_TAPS; k++) tap_d[k] = '0;
    tap_d[0] = data_in;
    for (int c = 0; c < N_CH; c++) begin
      if (int'(in_ch) == c) begin
        for (int k = 1; k < N_TAPS; k++) tap_d[k] = line_q[c][k-1];
      end
    end
  end

  for (genvar k = 0; k < N_TAPS; k++) begin : g_prod
    localparam int PF = PRODUCT_FRAC_WL_ARRAY[k];
    localparam logic signed [COE_W-1:0] C = COE_W'(COE_ARRAY[k]);
    logic signed [WW-1:0] full, aligned;
    assign full = WW'(tap_q[k]) * WW'(C);
    if (PF < FULL_FRAC) begin : g_floor
      assign aligned = (full >>> (FULL_FRAC - PF)) <<< (ACC_FRAC - PF);
    end else begin : g_ext
      assign aligned = full <<< (ACC_FRAC - FULL_FRAC);
    end
    assign prod_d[k] = aligned[ACC_W-1:0];
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < N_TAPS; k++) sum_d = sum_d + prod_q[k];
  end

  assign wide = QW'(sum_q);
  if (OUT_FRAC_WL < ACC_FRAC) begin : g_quant
    localparam int SH = ACC_FRAC - OUT_FRAC_WL;
    localparam logic signed [QW-1:0] HALF = QW'(64'sd1 <<< (SH - 1));
    if (ROUND_MODE == 1) begin : g_round
      assign q = (wide + HALF) >>> SH;
    end else begin : g_trunc
      assign q = wide >>> SH;
    end
  end else begin : g_widen
    assign q = wide <<< (OUT_FRAC_WL - ACC_FRAC);
  end

  always_comb begin
    ovf_d  = (q > OMAX) || (q < OMIN);
    dout_d = q[OUT_W-1:0];
`ifdef FIR_TDM_SAT_EN
    if (ovf_d) dout_d = q[QW-1] ? OMIN[OUT_W-1:0] : OMAX[OUT_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int k = 0; k < N_TAPS; k++) line_q[c][k] <= '0;
      end
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      out_ch    <= '0;
      ovf       <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (accept && int'(in_ch) == c) begin
          for (int k = 0; k < N_TAPS; k++) line_q[c][k] <= tap_d[k];
        end
      end
      v0_q      <= accept;
      v1_q      <= v0_q;
      v2_q      <= v1_q;
      out_valid <= v2_q;
      ovf       <= v2_q & ovf_d;
      if (v2_q) begin
        data_out <= dout_d;
        out_ch   <= ch2_q;
      end
    end
  end

  // Datapath registers need no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < N_TAPS; k++) tap_q[k] <= tap_d[k];
    end
    ch0_q <= in_ch;
    ch1_q <= ch0_q;
    ch2_q <= ch1_q;
    for (int k = 0; k < N_TAPS; k++) prod_q[k] <= prod_d[k];
    sum_q <= sum_d;
  end

endmodule

// File: tb/tb_fir_tdm.sv
// Self-checking bench for fir_tdm: three configurations, directed scenarios plus random stream
// checked every cycle against an arithmetic reference model.
`timescale 1ns/1ps
module tb_fir_tdm;
  localparam int NT = 15;
  localparam int NC = 3;
  localparam int ND = 3;

  localparam int COE0 [0:NT-1] = '{0: 64, 1: 128, 2: 64, default: 0};
  localparam int COE1 [0:NT-1] = '{0: 256, 1: 256, default: 0};
  localparam int COE2 [0:NT-1] = '{0: 128, 1: -77, 2: 300, 3: 5, 4: -1000, default: 0};
  localparam int PF0  [0:NT-1] = '{default: 16};
  localparam int PF2  [0:NT-1] = '{0: 16, 1: 6, 2: 20, 3: 9, 4: 12, default: 16};

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic [1:0]         in_ch = '0;
  logic signed [11:0] data_in = '0;
  logic signed [11:0] dout [ND];
  logic [1:0]         och  [ND];
  logic               ov   [ND];
  logic               of   [ND];

  always #5 clk = ~clk;

  fir_tdm #(.N_CH(NC), .COE_ARRAY(COE0), .PRODUCT_FRAC_WL_ARRAY(PF0), .ROUND_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .in_ch(in_ch), .in_valid(in_valid),
    .data_out(dout[0]), .out_ch(och[0]), .out_valid(ov[0]), .ovf(of[0]));
  fir_tdm #(.N_CH(NC), .COE_ARRAY(COE1), .PRODUCT_FRAC_WL_ARRAY(PF0), .ROUND_MODE(0)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .in_ch(in_ch), .in_valid(in_valid),
    .data_out(dout[1]), .out_ch(och[1]), .out_valid(ov[1]), .ovf(of[1]));
  fir_tdm #(.N_CH(NC), .COE_ARRAY(COE2), .PRODUCT_FRAC_WL_ARRAY(PF2), .ROUND_MODE(1)) dut2 (
    .clk(clk), .rst(rst), .data_in(data_in), .in_ch(in_ch), .in_valid(in_valid),
    .data_out(dout[2]), .out_ch(och[2]), .out_valid(ov[2]), .ovf(of[2]));

  typedef struct {int due; int data; int ch; int ovf;} exp_t;

  int   coe [ND][NT];
  int   pf  [ND][NT];
  int   rnd [ND];
  int   hist [ND][NC][NT];
  exp_t expq [ND][$];
  int   log_data [ND][$];
  int   log_ch   [ND][$];
  int   log_ovf  [ND][$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", name, d, cyc, act, exp);
    end
  endtask

  // Exact arithmetic: floor each product to its fraction width, sum, quantise, range-reduce.
  function automatic exp_t model(input int d, input int c);
    exp_t   e;
    longint acc = 0, full, v, q;
    int     af = 0, sh;
    for (int k = 0; k < NT; k++) if (pf[d][k] > af) af = pf[d][k];
    for (int k = 0; k < NT; k++) begin
      full = longint'(hist[d][c][k]) * longint'(coe[d][k]);
      if (pf[d][k] < 16) v = (full >>> (16 - pf[d][k])) <<< (af - pf[d][k]);
      else               v = full <<< (af - 16);
      acc += v;
    end
    sh = af - 8;
    if (rnd[d] == 1) q = (acc + (64'sd1 <<< (sh - 1))) >>> sh;
    else             q = acc >>> sh;
    e.ovf = (q > 2047 || q < -2048) ? 1 : 0;
`ifdef FIR_TDM_SAT_EN
    if (q > 2047)       e.data = 2047;
    else if (q < -2048) e.data = -2048;
    else                e.data = int'(q);
`else
    e.data = int'(((q + 2048) & 64'sd4095) - 2048);
`endif
    e.ch  = c;
    e.due = 0;
    return e;
  endfunction

  task automatic drive(input bit r, input bit v, input int c, input int x);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = r;
    in_valid = v;
    in_ch    = c[1:0];
    data_in  = x[11:0];
    for (int d = 0; d < ND; d++) begin
      if (r) begin
        while (expq[d].size() > 0 && expq[d][$].due > cyc) void'(expq[d].pop_back());
        for (int ch = 0; ch < NC; ch++) for (int k = 0; k < NT; k++) hist[d][ch][k] = 0;
      end else if (v && c < NC) begin
        for (int k = NT - 1; k > 0; k--) hist[d][c][k] = hist[d][c][k-1];
        hist[d][c][0] = x;
        e = model(d, c);
        e.due = cyc + 4;
        expq[d].push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 0, 0);
    idle(1);
    for (int d = 0; d < ND; d++) begin
      log_data[d].delete();
      log_ch[d].delete();
      log_ovf[d].delete();
    end
  endtask

  task automatic lit(input int d, input int idx, input int ed, input int ec, input int eo);
    if (idx < log_data[d].size()) begin
      chk("lit_data", d, log_data[d][idx], ed);
      chk("lit_ch", d, log_ch[d][idx], ec);
      chk("lit_ovf", d, log_ovf[d][idx], eo);
    end else begin
      chk("lit_count", d, log_data[d].size(), idx + 1);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        if (expq[d].size() > 0 && expq[d][0].due == cyc) begin
          chk("out_valid", d, int'(ov[d]), 1);
          chk("data_out", d, int'(dout[d]), expq[d][0].data);
          chk("out_ch", d, int'(och[d]), expq[d][0].ch);
          chk("ovf", d, int'(of[d]), expq[d][0].ovf);
          void'(expq[d].pop_front());
        end else begin
          chk("idle_valid", d, int'(ov[d]), 0);
        end
        if (ov[d]) begin
          log_data[d].push_back(int'(dout[d]));
          log_ch[d].push_back(int'(och[d]));
          log_ovf[d].push_back(int'(of[d]));
        end
      end
    end
  end

  initial begin
    int x, c;
    bit r, v;
    for (int k = 0; k < NT; k++) begin
      coe[0][k] = COE0[k]; coe[1][k] = COE1[k]; coe[2][k] = COE2[k];
      pf[0][k]  = PF0[k];  pf[1][k]  = PF0[k];  pf[2][k]  = PF2[k];
    end
    rnd[0] = 0; rnd[1] = 0; rnd[2] = 1;

    drive(1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, 0);
    chk_en = 1'b1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk("rst_data", d, int'(dout[d]), 0);
      chk("rst_ch", d, int'(och[d]), 0);
      chk("rst_ovf", d, int'(of[d]), 0);
    end

    // Impulse response
    do_reset();
    drive(0, 1, 0, 256); drive(0, 1, 0, 0); drive(0, 1, 0, 0); drive(0, 1, 0, 0);
    idle(5);
    lit(0, 0, 64, 0, 0); lit(0, 1, 128, 0, 0); lit(0, 2, 64, 0, 0); lit(0, 3, 0, 0, 0);

    // Interleaved channels: ch0 impulse, ch1 constant
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, (i == 0) ? 256 : 0);
      drive(0, 1, 1, 256);
    end
    idle(5);
    lit(0, 0, 64, 0, 0);  lit(0, 1, 64, 1, 0);  lit(0, 2, 128, 0, 0); lit(0, 3, 192, 1, 0);
    lit(0, 4, 64, 0, 0);  lit(0, 5, 256, 1, 0); lit(0, 6, 0, 0, 0);   lit(0, 7, 256, 1, 0);

    // Output range overflow
    do_reset();
    drive(0, 1, 0, 2047); drive(0, 1, 0, 2047);
    idle(5);
    lit(1, 0, 2047, 0, 0);
`ifdef FIR_TDM_SAT_EN
    lit(1, 1, 2047, 0, 1);
`else
    lit(1, 1, -2, 0, 1);
`endif

    // Rounding: +-1 LSB inputs on separate channels
    do_reset();
    drive(0, 1, 0, 1); drive(0, 1, 1, -1);
    idle(5);
    lit(0, 0, 0, 0, 0); lit(0, 1, -1, 1, 0);
    lit(2, 0, 1, 0, 0); lit(2, 1, 0, 1, 0);

    // Reset with results in flight (and a coincident sample), then impulse again
    do_reset();
    for (int i = 0; i < 6; i++) drive(0, 1, i % 2, 300 + i);
    drive(1, 1, 0, 500);
    idle(1);
    for (int d = 0; d < ND; d++) begin
      log_data[d].delete(); log_ch[d].delete(); log_ovf[d].delete();
    end
    drive(0, 1, 0, 256); drive(0, 1, 0, 0); drive(0, 1, 0, 0); drive(0, 1, 0, 0);
    idle(5);
    lit(0, 0, 64, 0, 0); lit(0, 1, 128, 0, 0); lit(0, 2, 64, 0, 0); lit(0, 3, 0, 0, 0);

    // Out-of-range channel mixed in
    do_reset();
    drive(0, 1, 0, 256); drive(0, 1, 3, 999); drive(0, 1, 0, 0); drive(0, 1, 3, -5);
    drive(0, 1, 0, 0); drive(0, 1, 0, 0);
    idle(5);
    chk("drop_count", 0, log_data[0].size(), 4);
    lit(0, 0, 64, 0, 0); lit(0, 1, 128, 0, 0); lit(0, 2, 64, 0, 0); lit(0, 3, 0, 0, 0);

    // Random stream
    do_reset();
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 64)) - 32;
      else                           x = int'($urandom_range(0, 4095)) - 2048;
      drive(r, v, c, x);
    end
    idle(6);
    for (int d = 0; d < ND; d++) chk("leftover", d, expq[d].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
